// File: rtl/common_types_pkg.sv
// common_types_pkg
//   Shared definitions for the AHB timer satellite: register offsets
//   (haddr[3:2]), CTRL field positions, the reset value of COMPARE and the
//   bus response FSM state encoding.
package common_types_pkg;

  // Register offsets, decoded from haddr[3:2]
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // CTRL field positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AR_BIT   = 1;
  localparam int CTRL_IRQ_BIT  = 2;
  localparam int CTRL_PS_LSB   = 8;
  localparam int CTRL_PS_MSB   = 15;

  // STATUS field positions
  localparam int STATUS_MATCH_BIT = 0;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
  localparam logic [2:0]  HSIZE_WORD  = 3'd2;

  // Bus response FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } resp_state_t;

  // Only 32-bit transfers are supported; everything else is answered ERROR.
  function automatic logic is_word(input logic [2:0] hsize);
    return hsize == HSIZE_WORD;
  endfunction

endpackage

// File: rtl/ahb_bus_if.sv
// ahb_bus_if
//   AHB-Lite slave-select bundle between the bus multiplexor and one
//   satellite.
//   satellite modport: hsel/haddr/htrans/hwrite/hsize/hwdata in,
//                      hrdata/hready/hresp out.
//   master modport   : the mirror image, for the bus side / bench.
interface ahb_bus_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport satellite (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata,
    output hrdata, hready, hresp
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata,
    input  hrdata, hready, hresp
  );
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler
//   8-bit prescale counter producing the timer tick.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   i_en       : CTRL.EN; counter held at 0 while low
//   i_clear    : CTRL write in progress; restarts the prescale period
//   i_prescale : CTRL.PRESCALE; tick every (PRESCALE+1) enabled cycles
//   o_tick     : one-cycle tick, high in the cycle the counter equals PRESCALE
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_clear,
  input  logic [7:0] i_prescale,
  output logic       o_tick
);

  logic [7:0] r_cnt;
  logic       w_tick;

  // Tick is combinational so the COUNT update lands on the same edge that
  // wraps the prescale counter; PRESCALE = 0 therefore ticks every cycle.
  assign w_tick = i_en & (r_cnt == i_prescale);
  assign o_tick = w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (!i_en || i_clear || w_tick) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ahb_timer_satellite.sv
// ahb_timer_satellite
//   AHB-Lite timer peripheral: CTRL / COUNT / COMPARE / STATUS registers,
//   a prescaled up-counter with compare match, and a level interrupt.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   abif : AHB satellite port (hsel, haddr, htrans, hwrite, hsize, hwdata in;
//          hrdata, hready, hresp out)
//   tmi  : timer interrupt, MATCH & IRQ_EN
module ahb_timer_satellite
  import common_types_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ahb_bus_if.satellite  abif,
  output logic          tmi
);

  // ---------------------------------------------------------------------
  // Bus response FSM
  // ---------------------------------------------------------------------
  resp_state_t r_state;
  logic [1:0]  r_addr;
  logic        r_write;

  logic        w_hready;
  logic        w_hresp;
  logic        w_accept;

  // ERR1 is the only wait state; hresp stays high across both error cycles.
  assign w_hready = (r_state != ST_ERR1);
  assign w_hresp  = (r_state == ST_ERR1) || (r_state == ST_ERR2);

  // ERR2 shows hready = 1 but deliberately takes no new address phase.
  assign w_accept = abif.hsel & abif.htrans[1] & w_hready & (r_state != ST_ERR2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= 2'd0;
      r_write <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCESS: begin
          if (w_accept) begin
            r_addr  <= abif.haddr[3:2];
            r_write <= abif.hwrite;
            r_state <= is_word(abif.hsize) ? ST_ACCESS : ST_ERR1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ERR1: r_state <= ST_ERR2;
        ST_ERR2: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Data-phase write strobes (commit at the edge ending the data phase)
  // ---------------------------------------------------------------------
  logic w_wr_phase;
  logic w_wr_ctrl;
  logic w_wr_count;
  logic w_wr_cmp;
  logic w_wr_status;

  assign w_wr_phase  = (r_state == ST_ACCESS) & r_write;
  assign w_wr_ctrl   = w_wr_phase & (r_addr == REG_CTRL);
  assign w_wr_count  = w_wr_phase & (r_addr == REG_COUNT);
  assign w_wr_cmp    = w_wr_phase & (r_addr == REG_COMPARE);
  assign w_wr_status = w_wr_phase & (r_addr == REG_STATUS);

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic        r_en;
  logic        r_auto;
  logic        r_irq_en;
  logic [7:0]  r_prescale;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_match;

  logic        w_tick;
  logic        w_hit;

  assign w_hit = (r_count == r_compare);

  timer_prescaler u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .i_en       (r_en),
    .i_clear    (w_wr_ctrl),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_prescale <= 8'd0;
      r_compare  <= COMPARE_RST;
    end else begin
      if (w_wr_ctrl) begin
        r_en       <= abif.hwdata[CTRL_EN_BIT];
        r_auto     <= abif.hwdata[CTRL_AR_BIT];
        r_irq_en   <= abif.hwdata[CTRL_IRQ_BIT];
        r_prescale <= abif.hwdata[CTRL_PS_MSB:CTRL_PS_LSB];
      end
      if (w_wr_cmp) begin
        r_compare <= abif.hwdata;
      end
    end
  end

  // COUNT: a bus write overrides any tick update in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (w_wr_count) begin
      r_count <= abif.hwdata;
    end else if (w_tick) begin
      r_count <= (w_hit && r_auto) ? 32'd0 : r_count + 32'd1;
    end
  end

  // MATCH: a new match beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match <= 1'b0;
    end else if (w_tick && w_hit) begin
      r_match <= 1'b1;
    end else if (w_wr_status && abif.hwdata[STATUS_MATCH_BIT]) begin
      r_match <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Read data, driven only during a read data phase
  // ---------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = 32'd0;
    if (r_state == ST_ACCESS && !r_write) begin
      case (r_addr)
        REG_CTRL:    w_rdata = {16'd0, r_prescale, 5'd0, r_irq_en, r_auto, r_en};
        REG_COUNT:   w_rdata = r_count;
        REG_COMPARE: w_rdata = r_compare;
        REG_STATUS:  w_rdata = {31'd0, r_match};
        default:     w_rdata = 32'd0;
      endcase
    end
  end

  assign abif.hrdata = w_rdata;
  assign abif.hready = w_hready;
  assign abif.hresp  = w_hresp;
  assign tmi         = r_match & r_irq_en;

  // Address bits outside [3:2] and htrans[0] do not affect decoding.
  logic w_unused;
  assign w_unused = ^{abif.haddr[31:4], abif.haddr[1:0], abif.htrans[0]};

endmodule

// File: tb/tb_ahb_timer_satellite.sv
module tb_ahb_timer_satellite;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_CNT  = 2'd1;
  localparam logic [1:0] A_CMP  = 2'd2;
  localparam logic [1:0] A_STS  = 2'd3;

  logic clk;
  logic rst;
  logic tmi;

  ahb_bus_if abif ();

  ahb_timer_satellite dut (
    .clk  (clk),
    .rst  (rst),
    .abif (abif),
    .tmi  (tmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic m_dp    = 1'b0;

  // ---------------------------------------------------------------------
  // Monitor: tracks data phases from the bus handshake and scores each
  // completed transfer against the oldest expectation.
  // ---------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_dp = 1'b0;
      end else begin
        automatic logic nxt = 1'b0;
        if (m_dp) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected data phase: no expectation queued");
          end else if (!abif.hready) begin
            n_total++;
            if (sb[0].err && abif.hresp) n_pass++;
            else $display("FAIL %s wait state: hresp=%0b, expected err=%0b",
                          sb[0].name, abif.hresp, sb[0].err);
            nxt = 1'b1;
          end else begin
            automatic exp_t e = sb.pop_front();
            n_total++;
            if (abif.hresp == e.err && abif.hrdata == e.rdata) n_pass++;
            else $display("FAIL %s: hrdata=%h hresp=%0b, expected hrdata=%h hresp=%0b",
                          e.name, abif.hrdata, abif.hresp, e.rdata, e.err);
          end
        end
        if (abif.hsel && abif.htrans[1] && abif.hready) nxt = 1'b1;
        m_dp = nxt;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver helpers (all return at posedge + 1)
  // ---------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic bus_addr(input logic wr, input logic [1:0] r, input logic [2:0] sz);
    abif.hsel   = 1'b1;
    abif.htrans = 2'b10;
    abif.haddr  = 32'hA000_0000 | {28'd0, r, 2'b00};
    abif.hwrite = wr;
    abif.hsize  = sz;
  endtask

  task automatic bus_idle();
    abif.hsel   = 1'b0;
    abif.htrans = 2'b00;
    abif.hwrite = 1'b0;
    abif.hsize  = 3'd2;
  endtask

  task automatic xfer(input logic wr, input logic [1:0] r, input logic [2:0] sz,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err, input string name);
    bus_addr(wr, r, sz);
    sb.push_back('{exp_rd, exp_err, name});
    @(posedge clk); #1;
    bus_idle();
    abif.hwdata = wdata;
    @(posedge clk); #1;
    if (exp_err) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d, input string name);
    xfer(1'b1, r, 3'd2, d, 32'd0, 1'b0, name);
  endtask

  task automatic rd(input logic [1:0] r, input logic [31:0] exp, input string name);
    xfer(1'b0, r, 3'd2, 32'd0, exp, 1'b0, name);
  endtask

  // Write followed immediately by a second transfer in its data phase.
  task automatic btb(input logic [1:0] r1, input logic [31:0] d1,
                     input logic wr2, input logic [1:0] r2, input logic [31:0] d2,
                     input logic [31:0] exp2, input string name);
    bus_addr(1'b1, r1, 3'd2);
    sb.push_back('{32'd0, 1'b0, {name, " w1"}});
    @(posedge clk); #1;
    bus_addr(wr2, r2, 3'd2);
    abif.hwdata = d1;
    sb.push_back('{wr2 ? 32'd0 : exp2, 1'b0, {name, " t2"}});
    @(posedge clk); #1;
    bus_idle();
    abif.hwdata = d2;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_tmi(input logic exp, input string name);
    @(negedge clk);
    chk(name, {31'd0, tmi}, {31'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    bus_idle();
    abif.haddr  = 32'd0;
    abif.hwdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst hready", {31'd0, abif.hready}, 32'd1);
    chk("rst hresp",  {31'd0, abif.hresp},  32'd0);
    chk("rst hrdata", abif.hrdata, 32'd0);
    chk("rst tmi",    {31'd0, tmi}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset values and CTRL field masking
    rd(A_CTRL, 32'd0,          "rd ctrl rst");
    rd(A_CNT,  32'd0,          "rd count rst");
    rd(A_CMP,  32'hFFFF_FFFF,  "rd compare rst");
    rd(A_STS,  32'd0,          "rd status rst");
    wr(A_CTRL, 32'hFFFF_FFF8,  "wr ctrl mask");
    rd(A_CTRL, 32'h0000_FF00,  "rd ctrl mask");
    wr(A_CTRL, 32'd0,          "wr ctrl 0");

    // BUSY transfer must be ignored
    abif.hsel = 1'b1; abif.htrans = 2'b01; abif.hwrite = 1'b1;
    abif.haddr = {28'd0, A_CMP, 2'b00}; abif.hsize = 3'd2;
    @(posedge clk); #1;
    bus_idle();
    abif.hwdata = 32'h1234;
    @(posedge clk); #1;
    rd(A_CMP, 32'hFFFF_FFFF, "busy ignored");

    // Prescale 3, compare 5, auto-reload, irq
    wr(A_CMP,  32'd5,          "wr compare 5");
    wr(A_CTRL, 32'h0000_0307,  "wr ctrl ps3");
    rd(A_CNT,  32'd0,          "ps3 count E+1");
    idle(1);
    rd(A_CNT,  32'd1,          "ps3 count E+4");
    idle(18);
    check_tmi(1'b0, "tmi before match");
    check_tmi(1'b1, "tmi at match");
    rd(A_CNT,  32'd0,          "auto reload count");
    rd(A_STS,  32'd1,          "status match");

    // Wrap from 0xFFFFFFFF matches the reset COMPARE value
    wr(A_CTRL, 32'd0,          "ctrl stop");
    wr(A_STS,  32'd1,          "clear match");
    rd(A_STS,  32'd0,          "status cleared");
    wr(A_CMP,  32'hFFFF_FFFF,  "compare max");
    wr(A_CTRL, 32'h0000_0005,  "ctrl en irq ps0");
    wr(A_CNT,  32'hFFFF_FFFF,  "count max");
    rd(A_CNT,  32'd0,          "count wrapped");
    check_tmi(1'b1, "tmi after wrap");
    rd(A_STS,  32'd1,          "status wrap match");

    // Back-to-back write then read; write beats the tick
    btb(A_CNT, 32'h10, 1'b0, A_CNT, 32'd0, 32'h10, "btb count");
    rd(A_CNT,  32'h12,         "count after btb");

    // Clear racing a match: set wins
    wr(A_CTRL, 32'h0000_0004,  "ctrl irq only");
    wr(A_STS,  32'd1,          "clear match 2");
    check_tmi(1'b0, "tmi cleared");
    wr(A_CNT,  32'h1000,       "count park");
    wr(A_CMP,  32'h20,         "compare 0x20");
    wr(A_CTRL, 32'h0000_0005,  "ctrl run");
    btb(A_CNT, 32'h20, 1'b1, A_STS, 32'd1, 32'd0, "btb clr race");
    check_tmi(1'b1, "tmi set wins");
    rd(A_STS,  32'd1,          "status set wins");
    wr(A_STS,  32'd1,          "clear match 3");
    check_tmi(1'b0, "tmi after clear");
    rd(A_STS,  32'd0,          "status after clear");

    // Non-word transfers get a two-cycle ERROR and change nothing
    xfer(1'b1, A_CMP, 3'd1, 32'h55, 32'd0, 1'b1, "hword wr compare");
    rd(A_CMP,  32'h20,         "compare unchanged");
    xfer(1'b0, A_CTRL, 3'd0, 32'd0, 32'd0, 1'b1, "byte rd ctrl");

    // Reset during ERR1
    bus_addr(1'b1, A_CMP, 3'd1);
    sb.push_back('{32'd0, 1'b1, "err aborted"});
    @(posedge clk); #1;
    bus_idle();
    chk("in err1 hready", {31'd0, abif.hready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("err rst hready", {31'd0, abif.hready}, 32'd1);
    chk("err rst hresp",  {31'd0, abif.hresp},  32'd0);
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    chk("err rst hready 2", {31'd0, abif.hready}, 32'd1);
    chk("err rst hresp 2",  {31'd0, abif.hresp},  32'd0);
    chk("err rst tmi",      {31'd0, tmi},         32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd(A_CTRL, 32'd0,          "post rst ctrl");
    rd(A_CNT,  32'd0,          "post rst count");
    rd(A_CMP,  32'hFFFF_FFFF,  "post rst compare");
    rd(A_STS,  32'd0,          "post rst status");

    begin
      int w;
      w = 0;
      while (sb.size() != 0 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      if (sb.size() != 0) begin
        n_total++;
        $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      end
    end
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_timer_satellite.md
AHB_TIMER_SATELLITE -- requirements
Module: ahb_timer_satellite

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port abif, ahb_bus_if satellite side, carrying the members in REQ-004 to REQ-007.
REQ-004 SHALL take inputs hsel 1, haddr 32, htrans 2, hwrite 1, hsize 3 and hwdata 32 from the bus multiplexor.
REQ-005 SHALL drive output hrdata, 32 bits: register read data during the data phase.
REQ-006 SHALL drive output hready, 1 bit: transfer complete / satellite ready.
REQ-007 SHALL drive output hresp, 1 bit: 0 = OKAY, 1 = ERROR.
REQ-008 SHALL drive output tmi, 1 bit: level interrupt to interrupt_in_sync[17].

Function
REQ-009 SHALL decode only haddr[3:2]: 0 = CTRL, 1 = COUNT, 2 = COMPARE, 3 = STATUS.
REQ-010 SHALL use CTRL fields: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[15:8] PRESCALE; all other bits read as 0.
REQ-011 SHALL define STATUS bit0 as MATCH; writing 1 clears it, writing 0 has no effect.
REQ-012 SHALL latch an address phase (addr, hwrite, hsize) when hsel & htrans[1] & hready are all 1; IDLE and BUSY transfers are ignored.
REQ-013 SHALL complete word (hsize = 2) transfers with zero wait states: data-phase hready = 1, hresp = 0.
REQ-014 SHALL commit a write with the data-phase hwdata at the clock edge that ends the data phase.
REQ-015 SHALL drive hrdata combinationally in the data phase from the register value before that edge; hrdata = 0 outside a read data phase.
REQ-016 SHALL answer a transfer with hsize != 2 with a two-cycle ERROR: cycle 1 hready = 0, hresp = 1; cycle 2 hready = 1, hresp = 1; no register changes.
REQ-017 SHALL be built as a response FSM with states IDLE, ACCESS, ERR1 and ERR2, with these transitions:
  - IDLE -> ACCESS or ERR1 on a latched address phase;
  - ACCESS -> ACCESS, ERR1 or IDLE according to the next address phase;
  - ERR1 -> ERR2;
  - ERR2 -> IDLE, with no new address phase accepted in ERR2.
REQ-018 SHALL keep an 8-bit prescale counter that, while EN = 1, increments each cycle and emits a one-cycle tick when it equals PRESCALE, then returns to 0; PRESCALE = 0 gives a tick every cycle.
REQ-019 SHALL hold the prescale counter at 0 while EN = 0, and clear it on any CTRL write.
REQ-020 SHALL, on a tick:
  - if COUNT == COMPARE, set MATCH and load COUNT with 0 when AUTO_RELOAD = 1, else with COUNT + 1;
  - otherwise load COUNT with COUNT + 1, wrapping modulo 2^32 (0xFFFFFFFF -> 0).
REQ-021 SHALL let a bus write to COUNT win over a same-cycle tick update.
REQ-022 SHALL let a MATCH set win over a same-cycle STATUS clear.
REQ-023 SHALL drive tmi = MATCH & IRQ_EN combinationally from registers.

Reset
REQ-024 SHALL, while rst = 1, clear CTRL, COUNT, STATUS and the prescale counter, set COMPARE = 0xFFFFFFFF, and put the FSM in IDLE.
REQ-025 SHALL hold outputs at hready = 1, hresp = 0, hrdata = 0 and tmi = 0 during reset.
REQ-026 SHALL abandon any in-flight transfer, including an ERROR in progress, when rst asserts mid-transfer; the first transfer after release is treated as new.

Structure
REQ-027 SHALL place the register offsets, CTRL bit positions and the FSM state enum in common_types_pkg.
REQ-028 SHALL contain one sub-module, timer_prescaler, owning the prescale counter and the tick output.

Verification
REQ-029 SHALL check: PRESCALE = 3, COMPARE = 5, EN = 1, AUTO_RELOAD = 1, IRQ_EN = 1 -> COUNT advances every 4 cycles; MATCH and tmi = 1 on the tick where COUNT was 5, then COUNT = 0.
REQ-030 SHALL check: write COUNT = 0xFFFFFFFF with EN = 1 and PRESCALE = 0 -> COUNT reads 0 one tick later; MATCH set, since the COMPARE reset value is 0xFFFFFFFF.
REQ-031 SHALL check: halfword (hsize = 1) write to COMPARE -> hready 0 then 1 with hresp = 1 in both cycles; COMPARE unchanged.
REQ-032 SHALL check: STATUS write of 0x1 in the same cycle as a match -> MATCH stays 1; a later write of 0x1 -> MATCH = 0 and tmi = 0.
REQ-033 SHALL check: back-to-back write COUNT = 0x10 then read COUNT with PRESCALE = 0 -> the read returns 0x10; a same-cycle tick is overridden by the write.
REQ-034 SHALL check: rst asserted during ERR1 -> next cycle hready = 1, hresp = 0, all registers at reset values.
